// File: rtl/ext_mem_responder.sv
// Off-chip byte-memory model for the accelerator master bus, with preload port and slave-reply merge.
// Build macro EXT_MEM_PROTOCOL_CHECK_EN enables the sticky err protocol checker (err tied 0 otherwise).
//
// state   | meaning
// IDLE    | bus and loader sampled; reads latch offset, writes commit here
// RD_WAIT | read latency countdown
// WR_WAIT | write-ack latency countdown (write already committed)
// ACK     | single-cycle response to the master
module ext_mem_responder #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 8,
   parameter int SIZE_W    = 4,
   parameter int BASE_ADDR = 0,
   parameter int MEMSIZE   = 64,
   parameter int RD_DELAY  = 2,
   parameter int WR_DELAY  = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              Mout_oe_ram,
   input  logic              Mout_we_ram,
   input  logic [ADDR_W-1:0] Mout_addr_ram,
   input  logic [DATA_W-1:0] Mout_Wdata_ram,
   input  logic [SIZE_W-1:0] Mout_data_ram_size,
   input  logic [DATA_W-1:0] Sout_Rdata_ram,
   input  logic              Sout_DataRdy,
   output logic [DATA_W-1:0] M_Rdata_ram,
   output logic              M_DataRdy,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_idx,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              busy,
   output logic              err
);
   localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
   localparam int MAX_D = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
   localparam int CNT_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;
   localparam logic [ADDR_W:0] WIN_LO  = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] WIN_LEN = (ADDR_W+1)'(MEMSIZE);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ACK} state_t;

   state_t            state, next_state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  off_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ack_q;
   logic [DATA_W-1:0] mem [MEMSIZE];
   logic [ADDR_W:0]   off_ext;
   logic              hit, req_rd, req_wr, ld_fire, ld_in_range;
   logic [DATA_W-1:0] wmask;

   // One extra bit keeps below-window addresses far above MEMSIZE after the subtract.
   assign off_ext     = {1'b0, Mout_addr_ram} - WIN_LO;
   assign hit         = off_ext < WIN_LEN;
   assign req_rd      = Mout_oe_ram & ~Mout_we_ram & hit;
   assign req_wr      = Mout_we_ram & ~Mout_oe_ram & hit;
   assign ld_ready    = (state == IDLE) & ~(hit & (Mout_oe_ram | Mout_we_ram));
   assign ld_fire     = ld_valid & ld_ready;
   assign ld_in_range = {1'b0, ld_idx} < WIN_LEN;
   assign busy        = (state != IDLE);
   assign M_Rdata_ram = rdata_q | Sout_Rdata_ram;
   assign M_DataRdy   = ack_q | Sout_DataRdy;

   always_comb begin
      for (int i = 0; i < DATA_W; i++) wmask[i] = (int'(Mout_data_ram_size) > i);
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_rd)      next_state = RD_WAIT;
            else if (req_wr) next_state = WR_WAIT;
         end
         RD_WAIT, WR_WAIT: if (cnt == '0) next_state = ACK;
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         state   <= next_state;
         ack_q   <= (next_state == ACK);
         rdata_q <= '0;
         if (state == RD_WAIT && next_state == ACK) rdata_q <= mem[off_q];
         if (state == IDLE) begin
            off_q <= off_ext[IDX_W-1:0];
            cnt   <= req_rd ? CNT_W'(RD_DELAY - 1) : CNT_W'(WR_DELAY - 1);
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Storage is intentionally not reset so preloaded contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (state == IDLE && req_wr)
         mem[off_ext[IDX_W-1:0]] <= (Mout_Wdata_ram & wmask) | (mem[off_ext[IDX_W-1:0]] & ~wmask);
      else if (ld_fire && ld_in_range)
         mem[ld_idx[IDX_W-1:0]] <= ld_data;
   end

`ifdef EXT_MEM_PROTOCOL_CHECK_EN
   logic [ADDR_W-1:0] addr_q;
   logic              err_q, type_chg;

   assign type_chg = (state == RD_WAIT) ? Mout_we_ram : Mout_oe_ram;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         err_q  <= 1'b0;
      end else if (state == IDLE) begin
         addr_q <= Mout_addr_ram;
         if (Mout_oe_ram && Mout_we_ram) err_q <= 1'b1;
      end else if ((state == RD_WAIT || state == WR_WAIT) && hit &&
                   (Mout_oe_ram || Mout_we_ram) &&
                   (Mout_addr_ram != addr_q || type_chg)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: directed scenarios plus random accesses vs. an array model.
module tb_ext_mem_responder;
   localparam int ADDR_W = 10, DATA_W = 8, SIZE_W = 4, BASE_ADDR = 0;
   localparam int MEMSIZE = 64, RD_DELAY = 2, WR_DELAY = 1;
`ifdef EXT_MEM_PROTOCOL_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic              clock = 1'b0, reset = 1'b0;
   logic              Mout_oe_ram = 1'b0, Mout_we_ram = 1'b0;
   logic [ADDR_W-1:0] Mout_addr_ram = '0;
   logic [DATA_W-1:0] Mout_Wdata_ram = '0;
   logic [SIZE_W-1:0] Mout_data_ram_size = '0;
   logic [DATA_W-1:0] Sout_Rdata_ram = '0;
   logic              Sout_DataRdy = 1'b0;
   logic [DATA_W-1:0] M_Rdata_ram;
   logic              M_DataRdy;
   logic              ld_valid = 1'b0;
   logic [ADDR_W-1:0] ld_idx = '0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_ready, busy, err;

   int passed = 0, total = 0, failed = 0;
   logic [7:0] model [MEMSIZE];

   ext_mem_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .BASE_ADDR(BASE_ADDR),
      .MEMSIZE(MEMSIZE), .RD_DELAY(RD_DELAY), .WR_DELAY(WR_DELAY)
   ) dut (
      .clock(clock), .reset(reset),
      .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
      .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size),
      .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
      .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
      .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ld_ready),
      .busy(busy), .err(err)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [7:0] d);
      ld_valid = 1'b1;
      ld_idx   = ADDR_W'(idx);
      ld_data  = d;
      @(posedge clock);
      #1 ld_valid = 1'b0;
      if (idx < MEMSIZE) model[idx] = d;
   endtask

   // Drives one request, holds it until an ack is seen (or a budget runs out), then drops it.
   task automatic bus_access(input logic oe, input logic we, input int addr, input logic [7:0] wd,
                             input logic [3:0] sz, output int ack_cyc, output logic [7:0] ack_data,
                             output int stray, output int busy_cyc);
      Mout_oe_ram        = oe;
      Mout_we_ram        = we;
      Mout_addr_ram      = ADDR_W'(addr);
      Mout_Wdata_ram     = wd;
      Mout_data_ram_size = sz;
      ack_cyc = -1; ack_data = '0; stray = 0; busy_cyc = 0;
      @(posedge clock);
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (busy) busy_cyc++;
         if (M_DataRdy) begin
            ack_cyc  = c;
            ack_data = M_Rdata_ram;
            break;
         end else if (M_Rdata_ram !== 8'h00) begin
            stray++;
         end
      end
      Mout_oe_ram = 1'b0;
      Mout_we_ram = 1'b0;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] wd, input int sz);
      logic [7:0] m;
      m = (sz >= 8) ? 8'hFF : 8'((1 << sz) - 1);
      return (wd & m) | (old & ~m);
   endfunction

   int         ack_cyc, stray, busy_cyc, kind, addr, sz, lr_hi;
   logic [7:0] ack_data, wd;

   initial begin
      // reset state
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("rst_rdy", M_DataRdy, 0);
      check("rst_rdata", M_Rdata_ram, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_ld_ready", ld_ready, 1);

      // fill the whole window so the model is fully known
      for (int i = 0; i < MEMSIZE; i++) preload(i, 8'($urandom_range(0, 255)));

      // 1: preloaded byte read back with RD_DELAY latency
      preload(5, 8'hA5);
      bus_access(1, 0, 5, 8'h00, 4'd8, ack_cyc, ack_data, stray, busy_cyc);
      check("t1_lat", ack_cyc, RD_DELAY);
      check("t1_data", ack_data, 8'hA5);
      check("t1_stray", stray, 0);
      check("t1_pulse_end", M_DataRdy, 0);
      check("t1_rdata_after", M_Rdata_ram, 0);
      check("t1_idle", busy, 0);

      // 2: partial and full byte writes
      preload(7, 8'h00);
      bus_access(0, 1, 7, 8'hFF, 4'd4, ack_cyc, ack_data, stray, busy_cyc);
      check("t2_wlat", ack_cyc, WR_DELAY);
      check("t2_wack_data", ack_data, 0);
      bus_access(1, 0, 7, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t2_rd_size4", ack_data, 8'h0F);
      bus_access(0, 1, 7, 8'hFF, 4'd8, ack_cyc, ack_data, stray, busy_cyc);
      bus_access(1, 0, 7, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t2_rd_size8", ack_data, 8'hFF);
      model[7] = 8'hFF;

      // 3: first address past the window gets no ack; slave reply passes through
      bus_access(1, 0, BASE_ADDR + MEMSIZE, 8'h00, 4'd8, ack_cyc, ack_data, stray, busy_cyc);
      check("t3_miss_ack", ack_cyc, -1);
      check("t3_miss_busy", busy_cyc, 0);
      Sout_DataRdy = 1'b1;
      Sout_Rdata_ram = 8'h3C;
      #1;
      check("t3_sout_rdy", M_DataRdy, 1);
      check("t3_sout_data", M_Rdata_ram, 8'h3C);
      Sout_DataRdy = 1'b0;
      Sout_Rdata_ram = 8'h00;
      @(posedge clock);
      #1;

      // 4: bus wins over a held loader; loader completes once back in IDLE
      ld_valid = 1'b1; ld_idx = 10'd20; ld_data = 8'h5A;
      Mout_oe_ram = 1'b1; Mout_addr_ram = 10'd9;
      #1 check("t4_blk_req", ld_ready, 0);
      lr_hi = 0;
      for (int c = 0; c < RD_DELAY + 2; c++) begin
         @(negedge clock);
         if (ld_ready) lr_hi++;
         if (c == RD_DELAY + 1) check("t4_ack_seen", M_DataRdy, 1);
      end
      Mout_oe_ram = 1'b0;
      check("t4_blk_through_ack", lr_hi, 0);
      @(posedge clock);
      #1 check("t4_ready_idle", ld_ready, 1);
      @(posedge clock);
      #1 ld_valid = 1'b0;
      model[20] = 8'h5A;
      bus_access(1, 0, 20, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t4_loaded", ack_data, 8'h5A);
      preload(0, 8'h77);
      preload(MEMSIZE, 8'hEE);
      bus_access(1, 0, 0, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t4_oob_drop", ack_data, 8'h77);

      // 5: simultaneous oe/we is ignored
      bus_access(1, 1, 3, 8'h12, 4'd8, ack_cyc, ack_data, stray, busy_cyc);
      check("t5_ack", ack_cyc, -1);
      check("t5_busy", busy_cyc, 0);
      check("t5_err", err, ERR_EXP);
      bus_access(1, 0, 3, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t5_mem_intact", ack_data, model[3]);

      // 6: reset during RD_WAIT aborts the access, memory survives
      Mout_oe_ram = 1'b1; Mout_addr_ram = 10'd5;
      @(posedge clock);
      #2 check("t6_busy_before", busy, 1);
      reset = 1'b0;
      #1;
      check("t6_busy_rst", busy, 0);
      check("t6_rdy_rst", M_DataRdy, 0);
      Mout_oe_ram = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("t6_err_cleared", err, 0);
      check("t6_no_late_ack", M_DataRdy, 0);
      bus_access(1, 0, 5, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t6_mem5", ack_data, 8'hA5);
      bus_access(1, 0, 7, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
      check("t6_mem7", ack_data, 8'hFF);

      // random traffic against the array model
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 4);
         wd   = 8'($urandom_range(0, 255));
         sz   = $urandom_range(0, 15);
         if (kind == 4) begin
            addr = $urandom_range(MEMSIZE, (1 << ADDR_W) - 1);
            bus_access(1, kind[0], addr, wd, 4'(sz), ack_cyc, ack_data, stray, busy_cyc);
            check("rnd_miss_ack", ack_cyc, -1);
         end else if (kind < 2) begin
            addr = $urandom_range(0, MEMSIZE - 1);
            bus_access(1, 0, addr, wd, 4'(sz), ack_cyc, ack_data, stray, busy_cyc);
            check("rnd_rd_lat", ack_cyc, RD_DELAY);
            check("rnd_rd_data", ack_data, model[addr]);
         end else begin
            addr = $urandom_range(0, MEMSIZE - 1);
            bus_access(0, 1, addr, wd, 4'(sz), ack_cyc, ack_data, stray, busy_cyc);
            model[addr] = merge(model[addr], wd, sz);
            check("rnd_wr_lat", ack_cyc, WR_DELAY);
            check("rnd_wr_data", ack_data, 0);
         end
         check("rnd_stray", stray, 0);
      end

      // final sweep of the whole window
      for (int i = 0; i < MEMSIZE; i++) begin
         bus_access(1, 0, i, 8'h00, 4'd0, ack_cyc, ack_data, stray, busy_cyc);
         check("sweep_data", ack_data, model[i]);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
